// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the sipo_rx serial-in/parallel-out receiver:
//   - state_t    : receiver FSM states (IDLE, SHIFT)
//   - DEF_WIDTH  : default frame width in bits
//   - cnt_w()    : width of the bit counter for a given frame width
// -----------------------------------------------------------------------------
package sipo_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 4;

   // Counter holds 0..WIDTH-1; never narrower than one bit.
   function automatic int cnt_w(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_shift_core
// Shift register plus bit counter for the SIPO receiver.
//   clk, reset  : clock, asynchronous active-high reset
//   load_first  : capture sdi as bit 0 of a new frame (counter -> 1)
//   shift_en    : capture sdi as the next bit of the current frame
//   sdi         : serial data bit
//   last        : counter sits at WIDTH-1 (next shifted bit completes the frame)
//   word        : assembled word including the bit being shifted this cycle
//   done        : frame completes on this edge (shift_en at the last bit)
// -----------------------------------------------------------------------------
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_first,
   input  logic             shift_en,
   input  logic             sdi,
   output logic             last,
   output logic [WIDTH-1:0] word,
   output logic             done
);

   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first;

   // MSB-first shifts left so the earliest bit migrates to the MSB;
   // LSB-first shifts right so the earliest bit ends in bit 0.
   always_comb begin
      shifted = sr_q;
      first   = '0;
      if (MSB_FIRST) begin
         shifted = {sr_q[WIDTH-2:0], sdi};
         first   = {{(WIDTH-1){1'b0}}, sdi};
      end else begin
         shifted = {sdi, sr_q[WIDTH-1:1]};
         first   = {sdi, {(WIDTH-1){1'b0}}};
      end
   end

   assign last = (cnt_q == LAST_IDX);
   assign done = shift_en && !load_first && last;
   assign word = shifted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         sr_q  <= '0;
      end else if (load_first) begin
         // Stale bits are cleared so a restarted frame carries no history.
         cnt_q <= CW'(1);
         sr_q  <= first;
      end else if (shift_en) begin
         cnt_q <= done ? '0 : cnt_q + CW'(1);
         sr_q  <= shifted;
      end
   end

endmodule

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx
// Serial-in/parallel-out receiver: reassembles sof-delimited serial frames
// into WIDTH-bit words presented on a valid/ready holding register.
//   clk, reset : clock, asynchronous active-high reset
//   sdi        : serial data bit
//   sdi_vld    : sdi valid this cycle (gaps allowed)
//   sof        : start of frame, qualified by sdi_vld
//   pdo        : received word (holding register)
//   pdo_vld    : pdo holds an unconsumed word
//   pdo_rdy    : consumer accepts pdo when pdo_vld && pdo_rdy
//   busy       : a frame is partially received
//   ovr_err    : one-cycle pulse, completed word dropped (holding reg full)
//   sync_err   : one-cycle pulse, sof mid-frame discarded the partial frame
// -----------------------------------------------------------------------------
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sdi,
   input  logic             sdi_vld,
   input  logic             sof,
   output logic [WIDTH-1:0] pdo,
   output logic             pdo_vld,
   input  logic             pdo_rdy,
   output logic             busy,
   output logic             ovr_err,
   output logic             sync_err
);

   state_t           state_q;
   state_t           state_d;
   logic             load_first;
   logic             shift_en;
   logic             sync_err_d;
   logic             core_last;
   logic             core_done;
   logic [WIDTH-1:0] core_word;
   logic             frame_done;
   logic             load_pdo;
   logic             ovr_d;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk        (clk),
      .reset      (reset),
      .load_first (load_first),
      .shift_en   (shift_en),
      .sdi        (sdi),
      .last       (core_last),
      .word       (core_word),
      .done       (core_done)
   );

   // Next-state decode. A sof in SHIFT restarts the frame in place.
   always_comb begin
      state_d    = state_q;
      load_first = 1'b0;
      shift_en   = 1'b0;
      sync_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (sdi_vld && sof) begin
               load_first = 1'b1;
               state_d    = SHIFT;
            end
         end
         SHIFT: begin
            if (sdi_vld) begin
               if (sof) begin
                  load_first = 1'b1;
                  sync_err_d = 1'b1;
               end else begin
                  shift_en = 1'b1;
                  if (core_last) begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A finished word loads only if the holding register is empty or
   // being drained this same cycle; otherwise it is dropped.
   always_comb begin
      frame_done = core_done;
      load_pdo   = frame_done && (!pdo_vld || pdo_rdy);
      ovr_d      = frame_done && pdo_vld && !pdo_rdy;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         busy     <= 1'b0;
         pdo      <= '0;
         pdo_vld  <= 1'b0;
         ovr_err  <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy     <= (state_d == SHIFT);
         ovr_err  <= ovr_d;
         sync_err <= sync_err_d;
         if (load_pdo) begin
            pdo     <= core_word;
            pdo_vld <= 1'b1;
         end else if (pdo_vld && pdo_rdy) begin
            pdo_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx
// Directed bench for sipo_rx. Two instances share the stimulus: one MSB-first
// and one LSB-first. Expected words are queued when a frame is driven and
// popped by a monitor whenever a word is handed off (pdo_vld && pdo_rdy).
// -----------------------------------------------------------------------------
module tb_sipo_rx;

   logic       clk;
   logic       reset;
   logic       sdi;
   logic       sdi_vld;
   logic       sof;
   logic       pdo_rdy;

   logic [3:0] pdo_m, pdo_l;
   logic       vld_m, vld_l;
   logic       busy_m, busy_l;
   logic       ovr_m, ovr_l;
   logic       syn_m, syn_l;

   int tests;
   int fails;
   int ovr_cnt_m, ovr_cnt_l, syn_cnt_m, syn_cnt_l;
   int o0, s0;

   logic [3:0] q_m[$];
   logic [3:0] q_l[$];
   logic [3:0] exp_m, exp_l;

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
      .clk      (clk),
      .reset    (reset),
      .sdi      (sdi),
      .sdi_vld  (sdi_vld),
      .sof      (sof),
      .pdo      (pdo_m),
      .pdo_vld  (vld_m),
      .pdo_rdy  (pdo_rdy),
      .busy     (busy_m),
      .ovr_err  (ovr_m),
      .sync_err (syn_m)
   );

   sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
      .clk      (clk),
      .reset    (reset),
      .sdi      (sdi),
      .sdi_vld  (sdi_vld),
      .sof      (sof),
      .pdo      (pdo_l),
      .pdo_vld  (vld_l),
      .pdo_rdy  (pdo_rdy),
      .busy     (busy_l),
      .ovr_err  (ovr_l),
      .sync_err (syn_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one cycle of input, then return just after the sampling edge.
   task automatic drive(input logic v, input logic s, input logic b);
      sdi_vld = v;
      sof     = s;
      sdi     = b;
      @(posedge clk);
      #1;
   endtask

   // bits[3] is sent first, with sof.
   task automatic send_frame(input logic [3:0] bits);
      drive(1'b1, 1'b1, bits[3]);
      drive(1'b1, 1'b0, bits[2]);
      drive(1'b1, 1'b0, bits[1]);
      drive(1'b1, 1'b0, bits[0]);
   endtask

   task automatic gap2();
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (vld_m && pdo_rdy) begin
            if (q_m.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL msb_unexpected_word observed=%0h expected=none", pdo_m);
            end else begin
               exp_m = q_m.pop_front();
               chk("msb_word", 32'(pdo_m), 32'(exp_m));
            end
         end
         if (vld_l && pdo_rdy) begin
            if (q_l.size() == 0) begin
               tests++;
               fails++;
               $error("FAIL lsb_unexpected_word observed=%0h expected=none", pdo_l);
            end else begin
               exp_l = q_l.pop_front();
               chk("lsb_word", 32'(pdo_l), 32'(exp_l));
            end
         end
         if (ovr_m) ovr_cnt_m++;
         if (ovr_l) ovr_cnt_l++;
         if (syn_m) syn_cnt_m++;
         if (syn_l) syn_cnt_l++;
      end
   end

   initial begin
      tests = 0; fails = 0;
      ovr_cnt_m = 0; ovr_cnt_l = 0; syn_cnt_m = 0; syn_cnt_l = 0;
      reset = 1'b0; sdi = 1'b0; sdi_vld = 1'b0; sof = 1'b0; pdo_rdy = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pdo_m",  32'(pdo_m),  32'h0);
      chk("rst_vld_m",  32'(vld_m),  32'h0);
      chk("rst_busy_m", 32'(busy_m), 32'h0);
      chk("rst_ovr_m",  32'(ovr_m),  32'h0);
      chk("rst_syn_m",  32'(syn_m),  32'h0);
      chk("rst_pdo_l",  32'(pdo_l),  32'h0);
      chk("rst_vld_l",  32'(vld_l),  32'h0);
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b1);              // vld without sof ignored in IDLE
      chk("idle_nosof_busy", 32'(busy_m), 32'h0);

      // Basic frame 1,0,1,1
      q_m.push_back(4'b1011); q_l.push_back(4'b1101);
      drive(1'b1, 1'b1, 1'b1);
      chk("t1_busy", 32'(busy_m), 32'h1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      chk("t1_vld_early", 32'(vld_m), 32'h0);
      drive(1'b1, 1'b0, 1'b1);
      chk("t1_vld_m", 32'(vld_m), 32'h1);
      chk("t1_pdo_m", 32'(pdo_m), 32'hb);
      chk("t1_vld_l", 32'(vld_l), 32'h1);
      chk("t1_pdo_l", 32'(pdo_l), 32'hd);
      chk("t1_busy_end", 32'(busy_m), 32'h0);
      drive(1'b0, 1'b0, 1'b0);
      chk("t1_vld_one_cycle", 32'(vld_m), 32'h0);

      // Back-to-back frames at full rate
      q_m.push_back(4'b0110); q_l.push_back(4'b0110);
      q_m.push_back(4'b1000); q_l.push_back(4'b0001);
      send_frame(4'b0110);
      send_frame(4'b1000);
      chk("b2b_vld", 32'(vld_m), 32'h1);
      chk("b2b_pdo", 32'(pdo_m), 32'h8);
      drive(1'b0, 1'b0, 1'b0);

      // Gappy frame
      q_m.push_back(4'b1011); q_l.push_back(4'b1101);
      drive(1'b1, 1'b1, 1'b1); gap2();
      chk("gap_busy1", 32'(busy_m), 32'h1);
      drive(1'b1, 1'b0, 1'b0); gap2();
      drive(1'b1, 1'b0, 1'b1); gap2();
      chk("gap_busy3", 32'(busy_m), 32'h1);
      chk("gap_vld_wait", 32'(vld_m), 32'h0);
      drive(1'b1, 1'b0, 1'b1);
      chk("gap_pdo_m", 32'(pdo_m), 32'hb);
      chk("gap_vld_m", 32'(vld_m), 32'h1);
      drive(1'b0, 1'b0, 1'b0);
      chk("gap_no_ovr",  32'(ovr_cnt_m), 32'h0);
      chk("gap_no_sync", 32'(syn_cnt_m), 32'h0);

      // Overrun with consumer stalled
      pdo_rdy = 1'b0;
      q_m.push_back(4'b1011); q_l.push_back(4'b1101);
      send_frame(4'b1011);
      chk("ovr_vld1", 32'(vld_m), 32'h1);
      o0 = ovr_cnt_m;
      send_frame(4'b0110);
      chk("ovr_pulse_m", 32'(ovr_m), 32'h1);
      chk("ovr_pulse_l", 32'(ovr_l), 32'h1);
      chk("ovr_hold_m", 32'(pdo_m), 32'hb);
      chk("ovr_hold_l", 32'(pdo_l), 32'hd);
      drive(1'b0, 1'b0, 1'b0);
      chk("ovr_pulse_end", 32'(ovr_m), 32'h0);
      chk("ovr_count_m", 32'(ovr_cnt_m), 32'(o0 + 1));
      chk("ovr_still_vld", 32'(vld_m), 32'h1);
      pdo_rdy = 1'b1;
      drive(1'b0, 1'b0, 1'b0);
      chk("ovr_drained", 32'(vld_m), 32'h0);

      // Sync error: 1,0 then sof with 0,1,1,0
      s0 = syn_cnt_m;
      q_m.push_back(4'b0110); q_l.push_back(4'b0110);
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      chk("sync_pulse", 32'(syn_m), 32'h1);
      chk("sync_busy", 32'(busy_m), 32'h1);
      drive(1'b1, 1'b0, 1'b1);
      chk("sync_pulse_end", 32'(syn_m), 32'h0);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      chk("sync_pdo_m", 32'(pdo_m), 32'h6);
      drive(1'b0, 1'b0, 1'b0);
      chk("sync_count_m", 32'(syn_cnt_m), 32'(s0 + 1));
      chk("sync_count_l", 32'(syn_cnt_l), 32'(s0 + 1));

      // Reset mid-frame with a held word
      pdo_rdy = 1'b0;
      send_frame(4'b1110);
      chk("rst2_vld_before", 32'(vld_m), 32'h1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      chk("rst2_busy_before", 32'(busy_m), 32'h1);
      o0 = ovr_cnt_m; s0 = syn_cnt_m;
      reset = 1'b1;
      #1;
      chk("rst2_pdo_m",  32'(pdo_m),  32'h0);
      chk("rst2_vld_m",  32'(vld_m),  32'h0);
      chk("rst2_busy_m", 32'(busy_m), 32'h0);
      chk("rst2_pdo_l",  32'(pdo_l),  32'h0);
      chk("rst2_errs",   32'({ovr_m, syn_m, ovr_l, syn_l}), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      pdo_rdy = 1'b1;
      q_m.push_back(4'b1011); q_l.push_back(4'b1101);
      send_frame(4'b1011);
      chk("rst2_after_pdo", 32'(pdo_m), 32'hb);
      drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
      chk("rst2_no_ovr",  32'(ovr_cnt_m), 32'(o0));
      chk("rst2_no_sync", 32'(syn_cnt_m), 32'(s0));
      chk("q_m_empty", 32'(q_m.size()), 32'h0);
      chk("q_l_empty", 32'(q_l.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that consumes the serial stream produced by the shift-register PISO stage and reassembles it into WIDTH-bit words. Bits are qualified per cycle and frames are delimited by a start-of-frame marker. Completed words are presented on a valid/ready output register for the next parallel consumer. It is the downstream partner of the PISO and shares its clock domain.

## Interface
- WIDTH, 4, bits per frame (≥2)
- MSB_FIRST, 1, 1: first received bit lands in pdo[WIDTH-1]; 0: first bit lands in pdo[0]
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- sdi  in  1  serial data bit
- sdi_vld  in  1  sdi is a valid bit this cycle; gaps are allowed
- sof  in  1  start of frame; meaningful only with sdi_vld=1
- pdo  out  WIDTH  received word (holding register)
- pdo_vld  out  1  pdo holds an unconsumed word
- pdo_rdy  in  1  consumer accepts pdo when pdo_vld&&pdo_rdy
- busy  out  1  a frame is partially received
- ovr_err  out  1  one-cycle pulse: completed word dropped because holding register full
- sync_err  out  1  one-cycle pulse: sof arrived mid-frame and the partial frame was discarded

## Operation
- Reset (async assert, sync release): state IDLE; bit counter 0; shift reg 0; pdo=0; pdo_vld=0; busy=0; ovr_err=0; sync_err=0.
- FSM states: IDLE, SHIFT.
- IDLE: sdi_vld&&sof → capture bit 0, counter=1, go SHIFT. sdi_vld without sof is ignored. Single-cycle frames do not exist (WIDTH≥2).
- SHIFT: each sdi_vld&&!sof cycle captures one bit and increments the counter. When the bit at counter=WIDTH-1 is captured, the frame is complete, counter→0, go IDLE.
- SHIFT with sdi_vld&&sof: partial frame discarded, sync_err pulses, bit taken as bit 0 of a new frame (counter=1, stay SHIFT).
- sdi_vld=0: no change to counter or shift reg in any state.
- MSB_FIRST=1: shift left, new bit into LSB; after WIDTH bits the first bit sits in MSB. MSB_FIRST=0: shift right, new bit into MSB.
- Holding register: on frame complete, load pdo with assembled word and set pdo_vld if pdo_vld=0 or (pdo_vld&&pdo_rdy) the same cycle. Otherwise keep old pdo and pulse ovr_err; new word is lost.
- pdo_vld clears on pdo_vld&&pdo_rdy unless a new word loads in that same cycle. pdo stable while pdo_vld&&!pdo_rdy.
- busy = (state==SHIFT), registered.

## Timing
- Latency: final bit sampled at edge N → pdo/pdo_vld valid after edge N (visible in cycle N+1).
- Back-to-back frames at full rate (sdi_vld=1 every cycle, sof every WIDTH cycles) lose no data if pdo_rdy=1 continuously.
- ovr_err and sync_err are registered, high for exactly one cycle after the causing edge.
- Reset asserted mid-frame or with pdo_vld=1: all state cleared immediately; partial frame and held word discarded; no error pulses.

## Structure
- Package sipo_pkg: state typedef (IDLE, SHIFT), default WIDTH constant, counter-width function ($clog2(WIDTH)).
- One sub-module, sipo_shift_core: shift register plus bit counter with load-first/shift/clear controls and a done strobe. Top sipo_rx holds the FSM, holding register, handshake and error pulses.

## Test plan
- WIDTH=4, MSB_FIRST=1, pdo_rdy=1: send 1,0,1,1 with sof on first bit → pdo=4'b1011, pdo_vld for one cycle, after final-bit edge.
- Same bits, MSB_FIRST=0 → pdo=4'b1101.
- Gappy input: 1,0,1,1 with sdi_vld low 2 cycles between each bit → pdo=4'b1011; busy high throughout; no errors.
- pdo_rdy=0, send 4'b1011 then 4'b0110 → pdo stays 4'b1011, ovr_err pulses once at second completion; raising pdo_rdy clears pdo_vld.
- Send 1,0 then sof with 0,1,1,0 → sync_err pulses once, pdo=4'b0110.
- Assert reset after 2 bits while pdo_vld=1 → all outputs 0 immediately; next full frame 4'b1011 received correctly.
